// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter
// Owns the single shared program/graphics memory port. HPS ROM download
// writes arrive as one-cycle strobes and are buffered in a small FIFO. The
// game core is held in reset while a download runs, and for a settle period
// after the last write reaches the port. After that, game CPU reads share the
// port with late download writes; buffered writes always win the port.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   dl_active/dl_wr/dl_addr/dl_data
//                                download stream from hps_io
//   cpu_req/cpu_addr             CPU read request (held until cpu_ack)
//   cpu_rdata/cpu_ack            read data with one-cycle completion pulse
//   mem_addr/mem_wdata/mem_we    registered memory port
//   mem_rdata                    synchronous read data, one cycle after address
//   game_reset                   active-high reset to the game core
//   dl_busy                      download session in DL, DRAIN or HOLD
//   dl_overflow                  sticky flag: a download write was dropped
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, core in reset, incoming writes are only buffered
// DL    | download active, FIFO drains to memory
// DRAIN | download ended, remaining buffered writes still retiring
// HOLD  | settle period, counts HOLD_CYCLES cycles, core still in reset
// RUN   | core released, CPU reads and late writes share the port
module rom_dl_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 256
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          game_reset,
    output logic          dl_busy,
    output logic          dl_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_DL, S_DRAIN, S_HOLD, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q, count_d;
    logic [AW+DW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [AW+DW-1:0]    head;
    logic                rd_p1_q, rd_p2_q;
    logic                cpu_ack_q, cpu_ack_d;
    logic [DW-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                mem_we_q;
    logic                game_reset_q, game_reset_d;
    logic                dl_busy_q, dl_busy_d;
    logic                overflow_q;

    logic drain_en, fifo_empty, fifo_full, pop, bypass, wr_issue, store, drop;
    logic abort, rd_busy, rd_issue;

    // IDLE only buffers; every other state drains the FIFO to memory.
    assign drain_en   = (state_q != S_IDLE);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = drain_en && !fifo_empty;
    // An empty FIFO forwards the incoming strobe straight to the port.
    assign bypass     = drain_en && fifo_empty && dl_wr;
    assign wr_issue   = pop || bypass;
    assign store      = dl_wr && !bypass && (!fifo_full || pop);
    assign drop       = dl_wr && !bypass && fifo_full && !pop;
    assign head       = fifo_empty ? {dl_addr, dl_data} : fifo_mem[rd_ptr_q];

    // Leaving RUN kills any read in flight; its data is never acknowledged.
    assign abort    = (state_q == S_RUN) && dl_active;
    assign rd_busy  = rd_p1_q || rd_p2_q || cpu_ack_q;
    assign rd_issue = (state_q == S_RUN) && !abort && cpu_req && !rd_busy
                      && fifo_empty && !dl_wr;

    always_comb begin
        count_d = count_q;
        if (store && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !store) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    // HOLD starts in the cycle the final write is on the memory port, so
    // game_reset releases HOLD_CYCLES cycles after that write.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dl_active) state_d = S_DL;
            end
            S_DL, S_DRAIN: begin
                if (dl_active) begin
                    state_d = S_DL;
                end else if (count_d == '0) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (dl_active) begin
                    state_d    = S_DL;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end
            end
            S_RUN: begin
                if (dl_active) state_d = S_DL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (wr_issue) begin
            mem_addr_d  = head[AW+DW-1:DW];
            mem_wdata_d = head[DW-1:0];
        end else if (rd_issue) begin
            mem_addr_d = cpu_addr;
        end
        cpu_ack_d    = rd_p2_q && !abort;
        cpu_rdata_d  = cpu_ack_d ? mem_rdata : cpu_rdata_q;
        game_reset_d = (state_d != S_RUN);
        dl_busy_d    = (state_d == S_DL) || (state_d == S_DRAIN) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_p1_q      <= 1'b0;
            rd_p2_q      <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            game_reset_q <= 1'b1;
            dl_busy_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            if (store) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q      <= count_d;
            rd_p1_q      <= rd_issue;
            rd_p2_q      <= rd_p1_q && !abort;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= wr_issue;
            game_reset_q <= game_reset_d;
            dl_busy_q    <= dl_busy_d;
            overflow_q   <= overflow_q || drop;
        end
    end

    always_ff @(posedge clk) begin
        if (store) fifo_mem[wr_ptr_q] <= {dl_addr, dl_data};
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign game_reset  = game_reset_q;
    assign dl_busy     = dl_busy_q;
    assign dl_overflow = overflow_q;

endmodule
